// File: rtl/qa_drv_memory_multi.sv
`default_nettype none
// ============================================================================
// Module   : qa_drv_memory_multi
// Purpose  : Round-robin multi-client CCI read/write driver with per-client
//            outstanding limits and tag-based response/ACK routing.
// Revision : 1.0 - initial release
// ============================================================================
module qa_drv_memory_multi #(
    parameter int N_CLIENTS       = 4,
    parameter int CCI_ADDR_WIDTH  = 58,
    parameter int CCI_DATA_WIDTH  = 512,
    parameter int CCI_TAG_WIDTH   = 13,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                  clk,
    input  logic                                  resetb,
    input  logic [N_CLIENTS*CCI_ADDR_WIDTH-1:0]   rd_req_addr,
    input  logic [N_CLIENTS-1:0]                  rd_req_cached,
    input  logic [N_CLIENTS-1:0]                  rd_req_valid,
    output logic [N_CLIENTS-1:0]                  rd_req_rdy,
    output logic [CCI_DATA_WIDTH-1:0]             rd_rsp_data,
    output logic [N_CLIENTS-1:0]                  rd_rsp_valid,
    input  logic [N_CLIENTS*CCI_ADDR_WIDTH-1:0]   wr_addr,
    input  logic [N_CLIENTS*CCI_DATA_WIDTH-1:0]   wr_data,
    input  logic [N_CLIENTS-1:0]                  wr_cached,
    input  logic [N_CLIENTS-1:0]                  wr_valid,
    output logic [N_CLIENTS-1:0]                  wr_rdy,
    output logic [2*N_CLIENTS-1:0]                wr_ack,
    output logic [CCI_ADDR_WIDTH-1:0]             c0_req_addr,
    output logic                                  c0_req_cached,
    output logic [CCI_TAG_WIDTH-1:0]              c0_req_tag,
    output logic                                  c0_req_valid,
    input  logic                                  c0_almfull,
    input  logic                                  c0_rsp_valid,
    input  logic [CCI_TAG_WIDTH-1:0]              c0_rsp_tag,
    input  logic [CCI_DATA_WIDTH-1:0]             c0_rsp_data,
    output logic [CCI_ADDR_WIDTH-1:0]             c1_req_addr,
    output logic [CCI_DATA_WIDTH-1:0]             c1_req_data,
    output logic                                  c1_req_cached,
    output logic [CCI_TAG_WIDTH-1:0]              c1_req_tag,
    output logic                                  c1_req_valid,
    input  logic                                  c1_almfull,
    input  logic                                  c0_wrack_valid,
    input  logic [CCI_TAG_WIDTH-1:0]              c0_wrack_tag,
    input  logic                                  c1_wrack_valid,
    input  logic [CCI_TAG_WIDTH-1:0]              c1_wrack_tag,
    output logic                                  err_underflow
);

    localparam int CID_W = $clog2(N_CLIENTS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    function automatic logic [N_CLIENTS-1:0] rr_grant(input logic [N_CLIENTS-1:0] elig,
                                                      input logic [CID_W-1:0]     ptr);
        logic [N_CLIENTS-1:0] g;
        logic [CID_W-1:0]     idx;
        logic                 found;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < N_CLIENTS; k++) begin
            idx = ptr + CID_W'(k);
            if (!found && elig[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [CID_W-1:0] oh_enc(input logic [N_CLIENTS-1:0] oh);
        logic [CID_W-1:0] r;
        r = '0;
        for (int k = 0; k < N_CLIENTS; k++)
            if (oh[k]) r = r | CID_W'(k);
        return r;
    endfunction

    logic [N_CLIENTS-1:0]      rd_elig, wr_elig, rd_gnt, wr_gnt, rd_uf, wr_uf;
    logic [CID_W-1:0]          rd_win, wr_win;
    logic [CID_W-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [2*N_CLIENTS-1:0]    wr_ack_q, wr_ack_d;
    logic [N_CLIENTS-1:0]      rd_rsp_valid_q, rd_rsp_valid_d;
    logic [CCI_DATA_WIDTH-1:0] rd_rsp_data_q, rd_rsp_data_d;
    logic                      c0_req_valid_q, c0_req_valid_d, c0_req_cached_q, c0_req_cached_d;
    logic [CCI_ADDR_WIDTH-1:0] c0_req_addr_q, c0_req_addr_d, c1_req_addr_q, c1_req_addr_d;
    logic [CCI_TAG_WIDTH-1:0]  c0_req_tag_q, c0_req_tag_d, c1_req_tag_q, c1_req_tag_d;
    logic                      c1_req_valid_q, c1_req_valid_d, c1_req_cached_q, c1_req_cached_d;
    logic [CCI_DATA_WIDTH-1:0] c1_req_data_q, c1_req_data_d;
    logic                      err_underflow_q, err_underflow_d;
    logic                      unused_tag_bits;

    assign unused_tag_bits = ^{c0_rsp_tag[CCI_TAG_WIDTH-1:CID_W],
                               c0_wrack_tag[CCI_TAG_WIDTH-1:CID_W],
                               c1_wrack_tag[CCI_TAG_WIDTH-1:CID_W]};

    assign rd_gnt = rr_grant(rd_elig, rd_ptr_q);
    assign wr_gnt = rr_grant(wr_elig, wr_ptr_q);
    assign rd_win = oh_enc(rd_gnt);
    assign wr_win = oh_enc(wr_gnt);

    for (genvar i = 0; i < N_CLIENTS; i++) begin : g_client
        logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
        logic             rd_hit;
        logic [1:0]       wr_dec;

        assign rd_hit = c0_rsp_valid && (c0_rsp_tag[CID_W-1:0] == CID_W'(i));
        assign wr_ack_d[2*i +: 2] =
            {1'b0, c0_wrack_valid && (c0_wrack_tag[CID_W-1:0] == CID_W'(i))} +
            {1'b0, c1_wrack_valid && (c1_wrack_tag[CID_W-1:0] == CID_W'(i))};
        assign wr_dec     = wr_ack_d[2*i +: 2];
        assign rd_elig[i] = rd_req_valid[i] && (rd_cnt_q < CNT_MAX) && !c0_almfull;
        assign wr_elig[i] = wr_valid[i] && (wr_cnt_q < CNT_MAX) && !c1_almfull;
        assign rd_uf[i]   = rd_hit && (rd_cnt_q == '0);
        assign wr_uf[i]   = ({{CNT_W{1'b0}}, wr_dec} > {2'b00, wr_cnt_q});

        // Surplus completions are delivered but clamp the count at zero.
        always_comb begin
            rd_cnt_d = rd_cnt_q + CNT_W'(rd_gnt[i]) - CNT_W'(rd_hit && !rd_uf[i]);
            if (wr_uf[i])
                wr_cnt_d = CNT_W'(wr_gnt[i]);
            else
                wr_cnt_d = wr_cnt_q + CNT_W'(wr_gnt[i]) - CNT_W'(wr_dec);
        end

        always_ff @(posedge clk) begin
            if (!resetb) begin
                rd_cnt_q <= '0;
                wr_cnt_q <= '0;
            end else begin
                rd_cnt_q <= rd_cnt_d;
                wr_cnt_q <= wr_cnt_d;
            end
        end
    end

    always_comb begin
        rd_ptr_d        = (|rd_gnt) ? rd_win + CID_W'(1) : rd_ptr_q;
        wr_ptr_d        = (|wr_gnt) ? wr_win + CID_W'(1) : wr_ptr_q;
        c0_req_valid_d  = |rd_gnt;
        c0_req_addr_d   = rd_req_addr[rd_win*CCI_ADDR_WIDTH +: CCI_ADDR_WIDTH];
        c0_req_cached_d = rd_req_cached[rd_win];
        c0_req_tag_d    = CCI_TAG_WIDTH'(rd_win);
        c1_req_valid_d  = |wr_gnt;
        c1_req_addr_d   = wr_addr[wr_win*CCI_ADDR_WIDTH +: CCI_ADDR_WIDTH];
        c1_req_data_d   = wr_data[wr_win*CCI_DATA_WIDTH +: CCI_DATA_WIDTH];
        c1_req_cached_d = wr_cached[wr_win];
        c1_req_tag_d    = CCI_TAG_WIDTH'(wr_win);
        rd_rsp_valid_d  = c0_rsp_valid ? (N_CLIENTS'(1) << c0_rsp_tag[CID_W-1:0]) : '0;
        rd_rsp_data_d   = c0_rsp_data;
        err_underflow_d = err_underflow_q || (|rd_uf) || (|wr_uf);
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            c0_req_valid_q  <= 1'b0;
            c1_req_valid_q  <= 1'b0;
            rd_rsp_valid_q  <= '0;
            wr_ack_q        <= '0;
            err_underflow_q <= 1'b0;
        end else begin
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            c0_req_valid_q  <= c0_req_valid_d;
            c1_req_valid_q  <= c1_req_valid_d;
            rd_rsp_valid_q  <= rd_rsp_valid_d;
            wr_ack_q        <= wr_ack_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    // Payload registers are qualified by their valids and need no reset.
    always_ff @(posedge clk) begin
        c0_req_addr_q   <= c0_req_addr_d;
        c0_req_cached_q <= c0_req_cached_d;
        c0_req_tag_q    <= c0_req_tag_d;
        c1_req_addr_q   <= c1_req_addr_d;
        c1_req_data_q   <= c1_req_data_d;
        c1_req_cached_q <= c1_req_cached_d;
        c1_req_tag_q    <= c1_req_tag_d;
        rd_rsp_data_q   <= rd_rsp_data_d;
    end

    assign rd_req_rdy    = rd_gnt;
    assign wr_rdy        = wr_gnt;
    assign rd_rsp_valid  = rd_rsp_valid_q;
    assign rd_rsp_data   = rd_rsp_data_q;
    assign wr_ack        = wr_ack_q;
    assign c0_req_valid  = c0_req_valid_q;
    assign c0_req_addr   = c0_req_addr_q;
    assign c0_req_cached = c0_req_cached_q;
    assign c0_req_tag    = c0_req_tag_q;
    assign c1_req_valid  = c1_req_valid_q;
    assign c1_req_addr   = c1_req_addr_q;
    assign c1_req_data   = c1_req_data_q;
    assign c1_req_cached = c1_req_cached_q;
    assign c1_req_tag    = c1_req_tag_q;
    assign err_underflow = err_underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_qa_drv_memory_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_qa_drv_memory_multi
// Purpose  : Directed scoreboard bench for qa_drv_memory_multi.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qa_drv_memory_multi;

    localparam int N = 4;
    localparam int A = 58;
    localparam int D = 512;
    localparam int T = 13;

    logic           clk = 1'b0;
    logic           resetb;
    logic [N*A-1:0] rd_req_addr, wr_addr;
    logic [N*D-1:0] wr_data;
    logic [N-1:0]   rd_req_cached, rd_req_valid, rd_req_rdy, rd_rsp_valid;
    logic [N-1:0]   wr_cached, wr_valid, wr_rdy;
    logic [D-1:0]   rd_rsp_data, c0_rsp_data, c1_req_data;
    logic [2*N-1:0] wr_ack;
    logic [A-1:0]   c0_req_addr, c1_req_addr;
    logic [T-1:0]   c0_req_tag, c1_req_tag, c0_rsp_tag, c0_wrack_tag, c1_wrack_tag;
    logic           c0_req_cached, c0_req_valid, c0_almfull, c0_rsp_valid;
    logic           c1_req_cached, c1_req_valid, c1_almfull;
    logic           c0_wrack_valid, c1_wrack_valid, err_underflow;

    int vectors = 0;
    int miscompares = 0;

    typedef struct { logic [T-1:0] tag; logic [A-1:0] addr; logic cached; } c0_exp_t;
    typedef struct { logic [T-1:0] tag; logic [A-1:0] addr; logic [D-1:0] data; logic cached; } c1_exp_t;
    typedef struct { logic [N-1:0] vld; logic [D-1:0] data; } rsp_exp_t;

    c0_exp_t        c0_q[$];
    c1_exp_t        c1_q[$];
    rsp_exp_t       rsp_q[$];
    logic [2*N-1:0] ack_q[$];

    always #5 clk = ~clk;

    qa_drv_memory_multi dut (
        .clk(clk), .resetb(resetb),
        .rd_req_addr(rd_req_addr), .rd_req_cached(rd_req_cached),
        .rd_req_valid(rd_req_valid), .rd_req_rdy(rd_req_rdy),
        .rd_rsp_data(rd_rsp_data), .rd_rsp_valid(rd_rsp_valid),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_cached(wr_cached),
        .wr_valid(wr_valid), .wr_rdy(wr_rdy), .wr_ack(wr_ack),
        .c0_req_addr(c0_req_addr), .c0_req_cached(c0_req_cached),
        .c0_req_tag(c0_req_tag), .c0_req_valid(c0_req_valid),
        .c0_almfull(c0_almfull), .c0_rsp_valid(c0_rsp_valid),
        .c0_rsp_tag(c0_rsp_tag), .c0_rsp_data(c0_rsp_data),
        .c1_req_addr(c1_req_addr), .c1_req_data(c1_req_data),
        .c1_req_cached(c1_req_cached), .c1_req_tag(c1_req_tag),
        .c1_req_valid(c1_req_valid), .c1_almfull(c1_almfull),
        .c0_wrack_valid(c0_wrack_valid), .c0_wrack_tag(c0_wrack_tag),
        .c1_wrack_valid(c1_wrack_valid), .c1_wrack_tag(c1_wrack_tag),
        .err_underflow(err_underflow)
    );

    function automatic logic [D-1:0] mk(input int k);
        logic [31:0] w;
        w = 32'hA5A50000 ^ 32'(k);
        return {16{w}};
    endfunction

    task automatic chk(input string nm, input logic [D-1:0] act, input logic [D-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitors: pop one expectation per DUT output beat
    always @(negedge clk) begin
        if (c0_req_valid === 1'b1) begin
            if (c0_q.size() == 0) chk("c0_unexpected_req", 1, 0);
            else begin
                c0_exp_t e;
                e = c0_q.pop_front();
                chk("c0_req_tag", c0_req_tag, e.tag);
                chk("c0_req_addr", c0_req_addr, e.addr);
                chk("c0_req_cached", c0_req_cached, e.cached);
            end
        end
        if (c1_req_valid === 1'b1) begin
            if (c1_q.size() == 0) chk("c1_unexpected_req", 1, 0);
            else begin
                c1_exp_t e;
                e = c1_q.pop_front();
                chk("c1_req_tag", c1_req_tag, e.tag);
                chk("c1_req_addr", c1_req_addr, e.addr);
                chk("c1_req_data", c1_req_data, e.data);
                chk("c1_req_cached", c1_req_cached, e.cached);
            end
        end
        if (rd_rsp_valid !== '0 && resetb === 1'b1) begin
            if (rsp_q.size() == 0) chk("rd_rsp_unexpected", rd_rsp_valid, 0);
            else begin
                rsp_exp_t e;
                e = rsp_q.pop_front();
                chk("rd_rsp_valid", rd_rsp_valid, e.vld);
                chk("rd_rsp_data", rd_rsp_data, e.data);
            end
        end
        if (wr_ack !== '0 && resetb === 1'b1) begin
            if (ack_q.size() == 0) chk("wr_ack_unexpected", wr_ack, 0);
            else chk("wr_ack", wr_ack, ack_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_step(input int c);
        logic [N-1:0] e;
        e = (c < 0) ? '0 : N'(1) << c;
        if (c >= 0) c0_q.push_back('{tag: T'(c), addr: A'(32'h100 + c), cached: rd_req_cached[c]});
        @(negedge clk);
        chk("rd_req_rdy", rd_req_rdy, e);
        tick();
    endtask

    task automatic wr_step(input int c);
        logic [N-1:0] e;
        e = (c < 0) ? '0 : N'(1) << c;
        if (c >= 0) c1_q.push_back('{tag: T'(c), addr: A'(32'h200 + c), data: mk(32'h50 + c),
                                     cached: wr_cached[c]});
        @(negedge clk);
        chk("wr_rdy", wr_rdy, e);
        tick();
    endtask

    task automatic set_rsp(input int c, input int k);
        c0_rsp_valid = 1'b1;
        c0_rsp_tag   = T'(c);
        c0_rsp_data  = mk(k);
        rsp_q.push_back('{vld: N'(1) << c, data: mk(k)});
    endtask

    task automatic rsp_cycle(input int c, input int k);
        set_rsp(c, k);
        tick();
        c0_rsp_valid = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetb = 1'b0;
        rd_req_valid = '0; wr_valid = '0;
        rd_req_cached = 4'b0101; wr_cached = 4'b1010;
        c0_almfull = 1'b0; c1_almfull = 1'b0;
        c0_rsp_valid = 1'b0; c0_rsp_tag = '0; c0_rsp_data = '0;
        c0_wrack_valid = 1'b0; c0_wrack_tag = '0;
        c1_wrack_valid = 1'b0; c1_wrack_tag = '0;
        for (int i = 0; i < N; i++) begin
            rd_req_addr[i*A +: A] = A'(32'h100 + i);
            wr_addr[i*A +: A]     = A'(32'h200 + i);
            wr_data[i*D +: D]     = mk(32'h50 + i);
        end
        repeat (3) tick();
        @(negedge clk);
        chk("reset_c0_valid", c0_req_valid, 0);
        chk("reset_c1_valid", c1_req_valid, 0);
        chk("reset_rd_rsp_valid", rd_rsp_valid, 0);
        chk("reset_wr_ack", wr_ack, 0);
        chk("reset_err_underflow", err_underflow, 0);
        tick();
        resetb = 1'b1;

        // Round-robin across all four readers
        rd_req_valid = 4'hF;
        rd_step(0); rd_step(1); rd_step(2); rd_step(3); rd_step(0);
        rd_req_valid = '0;
        tick(); tick();
        rsp_cycle(0, 1); rsp_cycle(0, 2); rsp_cycle(1, 3); rsp_cycle(2, 4); rsp_cycle(3, 5);
        tick(); tick();

        // Almost-full blocks all grants and leaves the pointer at 1
        c0_almfull = 1'b1; rd_req_valid = 4'hF;
        rd_step(-1); rd_step(-1);
        c0_almfull = 1'b0;
        chk("c0_valid_after_almfull", c0_req_valid, 0);
        rd_step(1);
        rd_req_valid = '0;
        tick(); tick();

        // Client 2 saturates at 8, one response reopens it
        rd_req_valid = 4'b0100;
        repeat (8) rd_step(2);
        rd_step(-1);
        set_rsp(2, 6);
        rd_step(-1);
        c0_rsp_valid = 1'b0;
        rd_step(2);

        // Client 1 climbs to 7; grant+response together holds it at 7
        rd_req_valid = 4'b0110;
        repeat (6) rd_step(1);
        set_rsp(1, 7);
        rd_step(1);
        c0_rsp_valid = 1'b0;
        rd_step(1);
        rd_step(-1);
        rd_req_valid = '0;
        tick(); tick();

        // Writes: arbitration, double ACK, then refill client 3 to its limit
        wr_valid = 4'b1001;
        wr_step(0); wr_step(3);
        wr_valid = 4'b1000;
        wr_step(3);
        wr_valid = '0;
        tick();
        c0_wrack_valid = 1'b1; c0_wrack_tag = T'(3);
        c1_wrack_valid = 1'b1; c1_wrack_tag = T'(3);
        ack_q.push_back(8'b10_00_00_00);
        tick();
        c0_wrack_tag = T'(0); c1_wrack_valid = 1'b0;
        ack_q.push_back(8'b00_00_00_01);
        tick();
        c0_wrack_valid = 1'b0;
        tick(); tick();
        chk("err_underflow_clean", err_underflow, 0);
        wr_valid = 4'b1000;
        repeat (8) wr_step(3);
        wr_step(-1);
        wr_valid = '0;
        tick(); tick();

        // Reset with reads in flight, including a grant in the reset cycle
        rd_req_valid = 4'b0001;
        rd_step(0); rd_step(0); rd_step(0);
        resetb = 1'b0;
        tick(); tick();
        resetb = 1'b1;
        rd_req_valid = '0;
        chk("c0_valid_after_reset", c0_req_valid, 0);
        rsp_cycle(0, 8); rsp_cycle(0, 9); rsp_cycle(0, 10);
        tick();
        chk("err_underflow_set", err_underflow, 1);
        rd_req_valid = 4'b0100;
        rd_step(2);
        rd_req_valid = 4'b0001;
        rd_step(0);
        rd_req_valid = '0;
        wr_valid = 4'b1000;
        wr_step(3);
        wr_valid = '0;
        repeat (4) tick();
        chk("err_underflow_sticky", err_underflow, 1);

        chk("c0_queue_drained", c0_q.size(), 0);
        chk("c1_queue_drained", c1_q.size(), 0);
        chk("rsp_queue_drained", rsp_q.size(), 0);
        chk("ack_queue_drained", ack_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
